rca4_sum_accumulator: RTL
=========================

Name: rca4_sum_accumulator

Overview:
- Downstream consumer of the registered 4-bit ripple-carry adder stage.
- Each accepted sample is the adder's 5-bit result {Co, S_3..S_0}, value range 0..31.
- Accumulates a programmable-length block of samples into a wide running total, then presents the total with a valid/ready handshake.
- Used as the result-collection stage for the adder synthesis benchmarks: a multi-sample sum-of-sums with saturation reporting.

Parameters:
ACC_W, 16, width of the accumulator and of out_sum (>= 5)
CNT_W, 8, width of block_len and out_count (>= 1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; returns the block to IDLE
in_valid  input  1  sample valid from the adder stage
in_ready  output  1  block can accept a sample
sum_in  input  4  adder sum bits, S_3..S_0 (bit 0 = S_0)
co_in  input  1  adder carry-out
block_len  input  CNT_W  samples per block; 0 treated as 1
out_valid  output  1  block result available
out_ready  input  1  downstream accepts the result
out_sum  output  ACC_W  accumulated total, saturated
out_count  output  CNT_W  samples accumulated in this block
out_ovf  output  1  saturation occurred during this block
busy  output  1  high in ACCUM or HOLD

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - State is IDLE.
  - in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0, busy=0.
  - Internal latched length is 1.
- Sample value: v = {co_in, sum_in}, zero-extended to ACC_W+1 bits. A sample is accepted when in_valid & in_ready at a clk edge.
- IDLE:
  - in_ready=1.
  - On accept: latch len = (block_len==0 ? 1 : block_len); acc=v; cnt=1; ovf=0.
  - If len==1, go to HOLD; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On accept: s = acc + v.
    - If s > 2^ACC_W-1, then acc = 2^ACC_W-1 and ovf=1.
    - Otherwise acc = s.
  - cnt = cnt+1. When the new cnt equals len, go to HOLD.
  - No accept means the state holds.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_sum=acc, out_count=cnt, out_ovf=ovf. These stay stable until out_ready.
  - On out_valid & out_ready, go to IDLE at that edge. The next sample is accepted no earlier than the following cycle.
- Latency: out_valid rises on the cycle after the edge at which the final sample was accepted.
- Registered outputs:
  - out_sum, out_count and out_ovf are registered and hold their last values after returning to IDLE.
  - out_valid is only high in HOLD.
- block_len is sampled only on the first accept of a block. Changes mid-block are ignored.
- Once set, ovf stays set until the next block starts. After saturation, acc stays at the maximum.
- clear:
  - Has priority over accept and over the handshake.
  - Next state is IDLE; cnt=0, acc=0, ovf=0, out_valid=0. Registered out_* values are left unchanged.
  - A sample presented in the same cycle as clear is dropped.
  - clear in HOLD discards the pending result.
- Async reset mid-operation immediately forces the reset values, including during HOLD.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Width rules:
  - The accumulator add is done at ACC_W+1 bits to detect overflow.
  - The cnt compare is CNT_W bits.
  - When len = 2^CNT_W-1 (maximum), cnt reaches that value without wrap.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles and release -> in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0, busy=0.
- Basic block: block_len=4; samples {co,sum} = 5,17,31,0 on consecutive cycles -> out_valid=1 on the cycle after the 4th accept, out_sum=53, out_count=4, out_ovf=0, in_ready=0 until out_ready.
- Backpressure and len 0: block_len=0, sample 9 -> HOLD with out_sum=9, out_count=1. Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0. Pulse out_ready -> IDLE next cycle, in_ready=1.
- Saturation with ACC_W=8: block_len=9, nine samples of 31 -> out_sum=255, out_ovf=1, out_count=9. The next block of len=2 with samples 1,2 -> out_sum=3, out_ovf=0.
- Clear mid-block: block_len=5; accept 3 samples of 10; assert clear together with in_valid (value 7) -> IDLE, sample dropped. A new block len=1 with sample 4 -> out_sum=4, out_count=1.
- Async reset in HOLD: drop rst_n while out_valid=1 -> out_valid, out_sum and out_count go to 0 immediately without a clk edge. After release, in_ready=1.

Source files
------------

// File: rtl/rca4_sum_accumulator_if.sv
// Handshake/bus bundle between the ripple-carry adder stage, the block accumulator
// and its downstream result consumer.
interface rca4_sum_accumulator_if #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       sum_in;
  logic             co_in;
  logic [CNT_W-1:0] block_len;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             busy;

  // Upstream adder / downstream consumer side
  modport master (
    output clear, in_valid, sum_in, co_in, block_len, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf, busy
  );

  // Accumulator side
  modport slave (
    input  clear, in_valid, sum_in, co_in, block_len, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf, busy
  );
endinterface

// File: rtl/rca4_sum_accumulator.sv
// Accumulates a programmable-length block of 5-bit adder results {co, sum} into a
// saturating running total and presents it with a valid/ready handshake.
module rca4_sum_accumulator #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rca4_sum_accumulator_if.slave bus
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic [SUM_W-1:0] sample;
  logic [SUM_W-1:0] sum_ext;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt_inc;

  // Sample, widened add and length helpers
  assign accept  = bus.in_valid & in_ready_q;
  assign sample  = SUM_W'({bus.co_in, bus.sum_in});
  assign sum_ext = SUM_W'(acc_q) + sample;
  assign len_eff = (bus.block_len == '0) ? CNT_W'(1) : bus.block_len;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= CNT_W'(1);
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, accumulate and result-capture logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          len_d = len_eff;
          acc_d = ACC_W'(sample);
          cnt_d = CNT_W'(1);
          ovf_d = 1'b0;
          if (len_eff == CNT_W'(1)) begin
            state_d     = HOLD;
            out_sum_d   = ACC_W'(sample);
            out_count_d = CNT_W'(1);
            out_ovf_d   = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          // Carry out of the ACC_W-bit field means the total saturates
          if (sum_ext[ACC_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_ext[ACC_W-1:0];
          end
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d     = HOLD;
            out_sum_d   = acc_d;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_d;
          end
        end
      end

      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over accept and handshake; published results are kept
    if (bus.clear) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      len_d       = len_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      out_ovf_d   = out_ovf_q;
    end

    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.busy      = busy_q;

endmodule
